// File: rtl/vscale_mem_responder_if.sv
// Split instruction/data memory bus between the vscale core and its memory.
// Address-phase signals come from the core; data-phase results come back
// from the memory side.
interface vscale_mem_responder_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_wait;
  logic        imem_badmem_e;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;

  modport master (
    output imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    input  imem_rdata, imem_wait, imem_badmem_e, dmem_rdata, dmem_wait, dmem_badmem_e
  );

  modport slave (
    input  imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
    output imem_rdata, imem_wait, imem_badmem_e, dmem_rdata, dmem_wait, dmem_badmem_e
  );
endinterface

// File: rtl/vscale_mem_responder.sv
// Memory responder for the vscale core: one shared word array serving an
// instruction fetch port and a data port, each with a pipelined address
// phase / data phase and a configurable number of wait cycles.
module vscale_mem_responder #(
  parameter int MEM_WORDS = 4096,
  parameter int IMEM_WAIT = 0,
  parameter int DMEM_WAIT = 0
) (
  input logic                  clk,
  input logic                  reset,
  vscale_mem_responder_if.slave bus
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] IWAIT = 4'(IMEM_WAIT);
  localparam logic [3:0] DWAIT = 4'(DMEM_WAIT);

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  logic [31:0] mem [MEM_WORDS];

  function automatic logic out_of_range(input logic [31:0] addr);
    return {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
  endfunction

  // Undefined sizes are faults so a garbled request can never touch memory.
  function automatic logic dmem_fault(input logic [2:0] size, input logic [31:0] addr);
    logic f;
    f = out_of_range(addr);
    case (size)
      SZ_B, SZ_BU: f = f;
      SZ_H, SZ_HU: f = f | addr[0];
      SZ_W:        f = f | (|addr[1:0]);
      default:     f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] size,
                                              input logic [1:0] off);
    logic [31:0]        sh;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    logic signed [31:0] bs;
    logic signed [31:0] hs;
    logic [31:0]        r;
    sh  = word >> {off, 3'b000};
    b8  = sh[7:0];
    h16 = sh[15:0];
    bs  = b8;
    hs  = h16;
    case (size)
      SZ_B:    r = bs;
      SZ_H:    r = hs;
      SZ_W:    r = word;
      SZ_BU:   r = {24'b0, sh[7:0]};
      SZ_HU:   r = {16'b0, sh[15:0]};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data is right-justified; replicating it puts the right bytes on
  // every lane the byte enables can select.
  function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_B:    d = {4{wdata[7:0]}};
      SZ_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // ---- p0: address phase ----
  logic iaccept_p0;
  logic daccept_p0;

  // ---- p1: data phase ----
  logic          ivld_p1;
  logic [3:0]    icnt_p1;
  logic [AW-1:0] iidx_p1;
  logic          ifault_p1;

  logic          dvld_p1;
  logic [3:0]    dcnt_p1;
  logic          dwen_p1;
  logic [2:0]    dsize_p1;
  logic [1:0]    doff_p1;
  logic [AW-1:0] didx_p1;
  logic          dfault_p1;
  logic          dcommit_p1;
  logic [3:0]    dbe_p1;
  logic [31:0]   dwd_p1;

  assign iaccept_p0 = !bus.imem_wait;
  assign daccept_p0 = !bus.dmem_wait;

  // Fetch port control: every accepted edge starts a new fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ivld_p1 <= 1'b0;
      icnt_p1 <= 4'd0;
    end else if (iaccept_p0) begin
      ivld_p1 <= 1'b1;
      icnt_p1 <= IWAIT;
    end else if (icnt_p1 != 4'd0) begin
      icnt_p1 <= icnt_p1 - 4'd1;
    end
  end

  // Fetch port address capture; only meaningful while ivld_p1 is set.
  always_ff @(posedge clk) begin
    if (iaccept_p0) begin
      iidx_p1   <= bus.imem_addr[AW+1:2];
      ifault_p1 <= out_of_range(bus.imem_addr) | (|bus.imem_addr[1:0]);
    end
  end

  // Data port control: an edge with dmem_en low leaves the data phase idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvld_p1 <= 1'b0;
      dcnt_p1 <= 4'd0;
    end else if (daccept_p0) begin
      dvld_p1 <= bus.dmem_en;
      dcnt_p1 <= bus.dmem_en ? DWAIT : 4'd0;
    end else if (dcnt_p1 != 4'd0) begin
      dcnt_p1 <= dcnt_p1 - 4'd1;
    end
  end

  // Data port request capture; only meaningful while dvld_p1 is set.
  always_ff @(posedge clk) begin
    if (daccept_p0) begin
      dwen_p1   <= bus.dmem_wen;
      dsize_p1  <= bus.dmem_size;
      doff_p1   <= bus.dmem_addr[1:0];
      didx_p1   <= bus.dmem_addr[AW+1:2];
      dfault_p1 <= dmem_fault(bus.dmem_size, bus.dmem_addr);
    end
  end

  // ---- p1 -> memory: store commit at the end of the completion cycle ----
  assign dcommit_p1 = dvld_p1 && dwen_p1 && !dfault_p1 && (dcnt_p1 == 4'd0);
  assign dbe_p1     = store_be(dsize_p1, doff_p1);
  assign dwd_p1     = store_data(dsize_p1, bus.dmem_wdata_delayed);

  // Byte-lane write; reset clears dvld_p1 asynchronously, so an abandoned
  // store can never reach this edge.
  always_ff @(posedge clk) begin
    if (dcommit_p1) begin
      for (int i = 0; i < 4; i++) begin
        if (dbe_p1[i]) mem[didx_p1][8*i +: 8] <= dwd_p1[8*i +: 8];
      end
    end
  end

  assign bus.imem_wait     = ivld_p1 && (icnt_p1 != 4'd0);
  assign bus.imem_badmem_e = ivld_p1 && ifault_p1;
  assign bus.imem_rdata    = (ivld_p1 && !ifault_p1) ? mem[iidx_p1] : 32'b0;

  assign bus.dmem_wait     = dvld_p1 && (dcnt_p1 != 4'd0);
  assign bus.dmem_badmem_e = dvld_p1 && dfault_p1;
  assign bus.dmem_rdata    = (dvld_p1 && !dfault_p1 && !dwen_p1)
                             ? load_extend(mem[didx_p1], dsize_p1, doff_p1) : 32'b0;

endmodule

// File: tb/tb_vscale_mem_responder.sv
// Bench for vscale_mem_responder: dut_a (no fetch waits, two data waits)
// carries the main load/store/fault table; dut_b (two fetch waits, no data
// waits) covers the other wait configuration.
module tb_vscale_mem_responder;
  localparam int MW   = 64;
  localparam int DW_A = 2;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vscale_mem_responder_if ifa ();
  vscale_mem_responder_if ifb ();

  vscale_mem_responder #(.MEM_WORDS(MW), .IMEM_WAIT(0), .DMEM_WAIT(DW_A)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  vscale_mem_responder #(.MEM_WORDS(MW), .IMEM_WAIT(2), .DMEM_WAIT(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        bad;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        bad;
    int          waits;
    string       name;
  } exp_t;

  vec_t vt[$];
  exp_t sb_q[$];
  exp_t iq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp, input logic bad,
                     input string name);
    vec_t v;
    v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata;
    v.exp = exp; v.bad = bad; v.name = name;
    vt.push_back(v);
  endtask

  // One complete dut_a data access; expectation queued when the request is driven.
  task automatic dmem_op(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_bad, input string name);
    exp_t e;
    int   w;
    ifa.dmem_en = 1'b1; ifa.dmem_wen = wen; ifa.dmem_size = size;
    ifa.dmem_addr = addr; ifa.dmem_wdata_delayed = wdata;
    e.rdata = exp_rd; e.bad = exp_bad; e.waits = DW_A; e.name = name;
    sb_q.push_back(e);
    @(posedge clk); #1;
    ifa.dmem_en = 1'b0;
    w = 0;
    @(negedge clk);
    while (ifa.dmem_wait === 1'b1 && w < 20) begin
      w++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check({e.name, "_rdata"}, ifa.dmem_rdata, e.rdata);
    check({e.name, "_bad"}, 32'(ifa.dmem_badmem_e), 32'(e.bad));
    check({e.name, "_waits"}, 32'(w), 32'(e.waits));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ia   [7];
    logic [31:0] idat [7];
    logic        ibad [7];
    exp_t        ie;
    bit          found;

    reset = 1'b1;
    ifa.imem_addr = 32'h0; ifa.dmem_en = 1'b0; ifa.dmem_wen = 1'b0;
    ifa.dmem_size = LW; ifa.dmem_addr = 32'h0; ifa.dmem_wdata_delayed = 32'h0;
    ifb.imem_addr = 32'h4; ifb.dmem_en = 1'b0; ifb.dmem_wen = 1'b0;
    ifb.dmem_size = LW; ifb.dmem_addr = 32'h0; ifb.dmem_wdata_delayed = 32'h0;

    // Reset state
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_a_iwait", 32'(ifa.imem_wait), 32'h0);
    check("rst_a_irdata", ifa.imem_rdata, 32'h0);
    check("rst_a_ibad", 32'(ifa.imem_badmem_e), 32'h0);
    check("rst_a_dwait", 32'(ifa.dmem_wait), 32'h0);
    check("rst_a_drdata", ifa.dmem_rdata, 32'h0);
    check("rst_a_dbad", 32'(ifa.dmem_badmem_e), 32'h0);
    check("rst_b_iwait", 32'(ifb.imem_wait), 32'h0);
    reset = 1'b0;

    // dut_b fetch wait pattern from the first edge after reset: 1,1,0 repeating
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("b_iwait_%0d", k), 32'(ifb.imem_wait), (k % 3 != 2) ? 32'h1 : 32'h0);
    end

    // dut_b zero-wait store then signed halfword load
    ifb.dmem_en = 1'b1; ifb.dmem_wen = 1'b1; ifb.dmem_size = LW;
    ifb.dmem_addr = 32'h4; ifb.dmem_wdata_delayed = 32'hA5A5A5A5;
    @(posedge clk); #1;
    ifb.dmem_en = 1'b0;
    @(negedge clk);
    check("b_st_wait", 32'(ifb.dmem_wait), 32'h0);
    check("b_st_rdata", ifb.dmem_rdata, 32'h0);
    @(posedge clk); #1;
    ifb.dmem_en = 1'b1; ifb.dmem_wen = 1'b0; ifb.dmem_size = LH; ifb.dmem_addr = 32'h6;
    @(posedge clk); #1;
    ifb.dmem_en = 1'b0;
    @(negedge clk);
    check("b_lh_wait", 32'(ifb.dmem_wait), 32'h0);
    check("b_lh_rdata", ifb.dmem_rdata, 32'hFFFFA5A5);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      @(negedge clk);
      if (ifb.imem_wait === 1'b0) begin
        found = 1'b1;
        check("b_fetch_rdata", ifb.imem_rdata, 32'hA5A5A5A5);
      end
    end
    if (!found) check("b_fetch_done", 32'h0, 32'h1);
    @(posedge clk); #1;

    // dut_a load/store/fault table
    add(1, LW,  32'h000, 32'h80FF7F01, 32'h0,        0, "sw_00");
    add(1, LW,  32'h004, 32'hDEADBEEF, 32'h0,        0, "sw_04");
    add(1, LW,  32'h008, 32'h00000000, 32'h0,        0, "sw_08");
    add(1, LW,  32'h020, 32'h01010101, 32'h0,        0, "sw_20");
    add(1, LW,  32'h024, 32'h55555555, 32'h0,        0, "sw_24");
    add(1, LW,  32'h010, 32'h11223344, 32'h0,        0, "sw_10");
    add(0, LBU, 32'h011, 32'h0,        32'h00000033, 0, "lbu_11");
    add(0, LW,  32'h010, 32'h0,        32'h11223344, 0, "lw_10");
    add(0, LB,  32'h003, 32'h0,        32'hFFFFFF80, 0, "lb_03");
    add(0, LBU, 32'h003, 32'h0,        32'h00000080, 0, "lbu_03");
    add(0, LH,  32'h002, 32'h0,        32'hFFFF80FF, 0, "lh_02");
    add(0, LHU, 32'h000, 32'h0,        32'h00007F01, 0, "lhu_00");
    add(0, LHU, 32'h002, 32'h0,        32'h000080FF, 0, "lhu_02");
    add(0, LB,  32'h001, 32'h0,        32'h0000007F, 0, "lb_01");
    add(0, LH,  32'h000, 32'h0,        32'h00007F01, 0, "lh_00");
    add(0, LW,  32'h004, 32'h0,        32'hDEADBEEF, 0, "lw_04");
    add(1, LB,  32'h009, 32'hAAAAAA5A, 32'h0,        0, "sb_09");
    add(0, LW,  32'h008, 32'h0,        32'h00005A00, 0, "lw_08a");
    add(1, LH,  32'h00A, 32'h00001234, 32'h0,        0, "sh_0a");
    add(0, LW,  32'h008, 32'h0,        32'h12345A00, 0, "lw_08b");
    add(0, LBU, 32'h00B, 32'h0,        32'h00000012, 0, "lbu_0b");
    add(0, LW,  32'h006, 32'h0,        32'h0,        1, "lw_mis");
    add(1, LW,  32'h100, 32'hFFFFFFFF, 32'h0,        1, "sw_oor");
    add(0, LW,  32'h100, 32'h0,        32'h0,        1, "lw_oor");
    add(0, LH,  32'h001, 32'h0,        32'h0,        1, "lh_mis");
    add(0, 3'd3, 32'h000, 32'h0,       32'h0,        1, "ld_sz3");
    add(1, LH,  32'h003, 32'hFFFFFFFF, 32'h0,        1, "sh_mis");
    add(1, 3'd6, 32'h000, 32'hFFFFFFFF, 32'h0,       1, "st_sz6");
    add(0, LW,  32'h000, 32'h0,        32'h80FF7F01, 0, "lw_00_kept");
    add(0, LW,  32'h008, 32'h0,        32'h12345A00, 0, "lw_08_kept");
    for (int i = 0; i < vt.size(); i++)
      dmem_op(vt[i].wen, vt[i].size, vt[i].addr, vt[i].wdata, vt[i].exp, vt[i].bad, vt[i].name);

    // dut_a back-to-back fetches, one-cycle lag
    ia   = '{32'h4, 32'h0, 32'h4, 32'h8, 32'h2, 32'h100, 32'h20};
    idat = '{32'hDEADBEEF, 32'h80FF7F01, 32'hDEADBEEF, 32'h12345A00, 32'h0, 32'h0, 32'h01010101};
    ibad = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i <= 7; i++) begin
      @(posedge clk); #1;
      if (i < 7) begin
        ifa.imem_addr = ia[i];
        ie.rdata = idat[i]; ie.bad = ibad[i]; ie.waits = 0; ie.name = $sformatf("fetch_%0d", i);
        iq.push_back(ie);
      end
      @(negedge clk);
      if (i > 0) begin
        ie = iq.pop_front();
        check({ie.name, "_rdata"}, ifa.imem_rdata, ie.rdata);
        check({ie.name, "_bad"}, 32'(ifa.imem_badmem_e), 32'(ie.bad));
        check({ie.name, "_wait"}, 32'(ifa.imem_wait), 32'h0);
      end
    end

    // Read-after-write: load issued in the store's completion cycle, fetch of the same word
    @(posedge clk); #1;
    ifa.imem_addr = 32'h20;
    ifa.dmem_en = 1'b1; ifa.dmem_wen = 1'b1; ifa.dmem_size = LW;
    ifa.dmem_addr = 32'h20; ifa.dmem_wdata_delayed = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(negedge clk); check("raw_st_w1", 32'(ifa.dmem_wait), 32'h1);
    @(negedge clk); check("raw_st_w2", 32'(ifa.dmem_wait), 32'h1);
    @(negedge clk); check("raw_st_done", 32'(ifa.dmem_wait), 32'h0);
    check("raw_imem_old", ifa.imem_rdata, 32'h01010101);
    ifa.dmem_wen = 1'b0;
    @(posedge clk); #1;
    ifa.dmem_en = 1'b0;
    @(negedge clk);
    check("raw_imem_new", ifa.imem_rdata, 32'hCAFEF00D);
    check("raw_ld_w1", 32'(ifa.dmem_wait), 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("raw_ld_done", 32'(ifa.dmem_wait), 32'h0);
    check("raw_ld_rdata", ifa.dmem_rdata, 32'hCAFEF00D);

    // Reset during the first wait cycle of a store
    @(posedge clk); #1;
    ifa.dmem_en = 1'b1; ifa.dmem_wen = 1'b1; ifa.dmem_size = LW;
    ifa.dmem_addr = 32'h24; ifa.dmem_wdata_delayed = 32'h77777777;
    @(posedge clk); #1;
    ifa.dmem_en = 1'b0;
    @(negedge clk);
    check("mid_pre_wait", 32'(ifa.dmem_wait), 32'h1);
    check("mid_pre_irdata", ifa.imem_rdata, 32'hCAFEF00D);
    #1 reset = 1'b1;
    #1;
    check("mid_dwait", 32'(ifa.dmem_wait), 32'h0);
    check("mid_dbad", 32'(ifa.dmem_badmem_e), 32'h0);
    check("mid_drdata", ifa.dmem_rdata, 32'h0);
    check("mid_iwait", 32'(ifa.imem_wait), 32'h0);
    check("mid_irdata", ifa.imem_rdata, 32'h0);
    check("mid_ibad", 32'(ifa.imem_badmem_e), 32'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    dmem_op(0, LW, 32'h24, 32'h0, 32'h55555555, 0, "post_rst_lw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vscale_mem_responder.md
Name: vscale_mem_responder

Overview:
- Memory-side responder for the core's split imem/dmem request interface. Implements a pipelined address-phase/data-phase protocol with configurable wait states, load extraction with sign/zero extension, store byte-lane steering, and bad-address/misalignment reporting.
- Used as the simulation and on-chip RAM target behind the core. Backing store is a single word array shared by both ports.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words; valid byte addresses are 0 .. 4*MEM_WORDS-1.
- IMEM_WAIT, 0, wait cycles inserted per instruction fetch (0..15).
- DMEM_WAIT, 0, wait cycles inserted per data access (0..15).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  input  32  fetch byte address; address phase every cycle.
- imem_rdata  output  32  fetch data; data phase.
- imem_wait  output  1  fetch data phase not complete.
- imem_badmem_e  output  1  fetch fault: misaligned or out of range.
- dmem_en  input  1  data access request; address phase.
- dmem_wen  input  1  1 = store; address phase.
- dmem_size  input  3  funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU; address phase.
- dmem_addr  input  32  data byte address; address phase.
- dmem_wdata_delayed  input  32  store data, right-justified; data phase.
- dmem_rdata  output  32  extended load data; data phase.
- dmem_wait  output  1  data phase not complete.
- dmem_badmem_e  output  1  data fault.

Behaviour:
- Reset (async, active-high):
  - Both data-phase valid flags cleared, wait counters cleared, pending store discarded.
  - imem_wait, dmem_wait, imem_badmem_e and dmem_badmem_e are 0; imem_rdata and dmem_rdata are 0.
  - Memory array contents are not reset.
- Protocol, per port:
  - Address-phase inputs are sampled at a clk edge only when that port's wait output is 0.
  - The sampled access becomes the data phase in the following cycle.
  - While wait is 1, address-phase inputs are ignored; the core holds them stable.
- imem port:
  - Every accepted edge starts a fetch; there is no enable.
  - Data phase lasts IMEM_WAIT+1 cycles: wait=1 for IMEM_WAIT cycles, then wait=0 for one cycle.
  - With IMEM_WAIT=0 this gives one-cycle latency and back-to-back fetches every cycle.
- dmem port:
  - An access is accepted only if dmem_en=1; otherwise the data phase is idle: wait=0, badmem=0, rdata=0.
  - An accepted access with DMEM_WAIT=N holds wait=1 for N cycles, then wait=0 for one completion cycle.
- Wait counter:
  - Loaded with the port's WAIT parameter on accept; decrements each cycle while nonzero.
  - wait = valid AND (count != 0).
- Fault detection, latched at accept and held for the whole data phase:
  - Out of range: addr[31:2] >= MEM_WORDS.
  - Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0, imem with addr[1:0]!=0.
  - Undefined dmem_size (3, 6, 7) is treated as a fault.
  - A faulted access never writes memory; rdata=0.
- Loads:
  - During the data phase, rdata is read combinationally from the latched word index.
  - Byte/halfword lanes are selected by latched addr[1:0].
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
- Stores:
  - Committed at the clk edge ending the completion cycle (wait=0), using dmem_wdata_delayed sampled at that edge.
  - Byte enables come from size/addr[1:0]: B writes one lane (wdata[7:0]), H writes two lanes (wdata[15:0]), W writes all four.
  - Unwritten lanes are preserved.
  - dmem_rdata during a store data phase is 0.
- Read-after-write:
  - A load whose address phase coincides with a store's completion cycle sees the new data, because its data phase starts after the commit edge.
  - An imem fetch of a word being stored in the same cycle returns the old data; a later fetch returns the new data.
- Simultaneous events:
  - The ports are fully independent; one port's waits never stall the other port's counter.
- Reset mid-operation:
  - An in-progress data phase is abandoned and its store is not committed.
  - The first access is accepted at the first clk edge after reset deasserts.

Test Plan:
- IMEM_WAIT=0; preload mem[1]=32'hDEADBEEF. Drive imem_addr=4 -> next cycle imem_rdata=DEADBEEF, imem_wait=0. Sequential addresses 0,4,8 -> data every cycle, one-cycle lag.
- DMEM_WAIT=2: store W 32'h11223344 to addr 0x10, then load BU from 0x11 -> store shows wait=1,1,0 with write on the completion edge; load returns 32'h00000033 after two wait cycles.
- Sign extension: mem[0]=32'h80FF7F01. LB 0x3 -> FFFFFF80. LBU 0x3 -> 00000080. LH 0x2 -> FFFF80FF. LHU 0x0 -> 00007F01.
- Byte store: mem[2]=0. SB wdata=32'hAAAAAA5A at 0x9 -> mem[2]=32'h00005A00. SH 32'h1234 at 0xA -> mem[2]=32'h12345A00.
- Faults: LW 0x6 -> dmem_badmem_e=1, rdata=0. SW to 4*MEM_WORDS -> badmem=1, memory unchanged. imem_addr=0x2 -> imem_badmem_e=1.
- Assert reset during wait cycle 1 of a DMEM_WAIT=3 store -> all outputs 0 immediately, target word unchanged, and the access after reset completes normally.
